// File: rtl/entry_id_allocator.sv
// -----------------------------------------------------------------------------
// entry_id_allocator
//   Hands out entry indices from a pool of ENTRY_NUM entries and takes them
//   back. The lowest free index is always offered combinationally. A grant is
//   made in the same cycle as the request whenever any entry is free.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst            : synchronous active-high reset
//   flush_i        : release every entry at the next edge (error flag is kept)
//   alloc_req_i    : allocation request
//   alloc_gnt_o    : request granted this cycle (combinational)
//   alloc_id_o     : lowest free index (combinational, valid when not full)
//   dealloc_vld_i  : release request
//   dealloc_id_i   : index being released
//   busy_vec_o     : registered busy bitmap, bit i set = entry i allocated
//   free_cnt_o     : registered count of free entries
//   full_o         : no entry free
//   empty_o        : every entry free
//   err_o          : sticky flag, set by releasing an idle or out-of-range id
// -----------------------------------------------------------------------------

// Lowest-index-first priority encoder. Returns 0 when no bit is set.
module prio_enc #(
  parameter int SEL_WIDTH = 8,
  parameter int IDX_W     = $clog2(SEL_WIDTH)
) (
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [IDX_W-1:0]     idx
);

  always_comb begin
    // NOTE: default first so every path assigns idx and no latch is inferred.
    idx = '0;
    // Scan downward so the lowest set bit is the last one written and wins.
    for (int i = SEL_WIDTH - 1; i >= 0; i--) begin
      if (sel[i]) idx = IDX_W'(i);
    end
  end

endmodule

module entry_id_allocator #(
  parameter int ENTRY_NUM = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         alloc_req_i,
  output logic                         alloc_gnt_o,
  output logic [$clog2(ENTRY_NUM)-1:0] alloc_id_o,
  input  logic                         dealloc_vld_i,
  input  logic [$clog2(ENTRY_NUM)-1:0] dealloc_id_i,
  output logic [ENTRY_NUM-1:0]         busy_vec_o,
  output logic [$clog2(ENTRY_NUM+1)-1:0] free_cnt_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         err_o
);

  localparam int ID_W  = $clog2(ENTRY_NUM);
  localparam int CNT_W = $clog2(ENTRY_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ENTRY_NUM);

  logic [ENTRY_NUM-1:0] busy_q;
  logic [CNT_W-1:0]     free_cnt_q;
  logic                 err_q;

  logic [ENTRY_NUM-1:0] free_vec;
  logic                 id_in_range;
  logic                 dealloc_ok;
  logic [ENTRY_NUM-1:0] busy_d;
  logic [CNT_W-1:0]     free_cnt_d;

  // ---------------------------------------------------------------------------
  // Grant path: only registered state feeds the encoder, so an entry released
  // this cycle is not offered until the next one.
  // ---------------------------------------------------------------------------
  assign free_vec = ~busy_q;

  prio_enc #(
    .SEL_WIDTH (ENTRY_NUM),
    .IDX_W     (ID_W)
  ) u_free_enc (
    .sel (free_vec),
    .idx (alloc_id_o)
  );

  assign full_o      = (free_cnt_q == '0);
  assign empty_o     = (free_cnt_q == CNT_MAX);
  assign alloc_gnt_o = alloc_req_i & ~full_o;

  // ---------------------------------------------------------------------------
  // Release qualification. With a power-of-two pool every encodable id is in
  // range; otherwise ids at or above ENTRY_NUM are rejected before the bitmap
  // is looked at.
  // ---------------------------------------------------------------------------
  if (ENTRY_NUM == (1 << ID_W)) begin : g_pow2
    assign id_in_range = 1'b1;
  end else begin : g_npow2
    assign id_in_range = (dealloc_id_i < ID_W'(ENTRY_NUM));
  end

  assign dealloc_ok = dealloc_vld_i & id_in_range & busy_q[dealloc_id_i];

  // A grant and a valid release can never target the same entry (the grant
  // picks a free one, the release a busy one), so both bit updates apply.
  always_comb begin
    busy_d     = busy_q;
    free_cnt_d = free_cnt_q;
    if (alloc_gnt_o) busy_d[alloc_id_o]   = 1'b1;
    if (dealloc_ok)  busy_d[dealloc_id_i] = 1'b0;
    case ({alloc_gnt_o, dealloc_ok})
      2'b10:   free_cnt_d = free_cnt_q - 1'b1;
      2'b01:   free_cnt_d = free_cnt_q + 1'b1;
      default: free_cnt_d = free_cnt_q;
    endcase
  end

  // Reset beats flush, flush beats grant/release. The error flag survives a
  // flush and only reset clears it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      busy_q     <= '0;
      free_cnt_q <= CNT_MAX;
      err_q      <= 1'b0;
    end else begin
      if (flush_i) begin
        busy_q     <= '0;
        free_cnt_q <= CNT_MAX;
      end else begin
        busy_q     <= busy_d;
        free_cnt_q <= free_cnt_d;
      end
      if (dealloc_vld_i && !dealloc_ok) err_q <= 1'b1;
    end
  end

  assign busy_vec_o = busy_q;
  assign free_cnt_o = free_cnt_q;
  assign err_o      = err_q;

  // The counter is a cached popcount of the free bitmap; they must never drift.
  cnt_matches_bitmap: assert property (@(posedge clk) disable iff (rst)
    free_cnt_q == CNT_W'($countones(~busy_q)));

endmodule

// File: tb/tb_entry_id_allocator.sv
// -----------------------------------------------------------------------------
// tb_entry_id_allocator
//   Drives the allocator one cycle at a time. Each cycle the expected outputs
//   are computed from a behavioural model of the pool, pushed to a queue, then
//   popped and compared against the DUT half a cycle away from the clock edge.
//   Directed scenarios add explicit constant checks on top.
// -----------------------------------------------------------------------------
module tb_entry_id_allocator;

  localparam int N     = 8;
  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic            alloc_req_i;
  logic            alloc_gnt_o;
  logic [ID_W-1:0] alloc_id_o;
  logic            dealloc_vld_i;
  logic [ID_W-1:0] dealloc_id_i;
  logic [N-1:0]    busy_vec_o;
  logic [CNT_W-1:0] free_cnt_o;
  logic            full_o;
  logic            empty_o;
  logic            err_o;

  entry_id_allocator #(.ENTRY_NUM(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .alloc_req_i   (alloc_req_i),
    .alloc_gnt_o   (alloc_gnt_o),
    .alloc_id_o    (alloc_id_o),
    .dealloc_vld_i (dealloc_vld_i),
    .dealloc_id_i  (dealloc_id_i),
    .busy_vec_o    (busy_vec_o),
    .free_cnt_o    (free_cnt_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            gnt;
    logic [ID_W-1:0] id;
    logic [N-1:0]    busy;
    int              cnt;
    logic            full;
    logic            empty;
    logic            err;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  logic [N-1:0] m_busy;
  logic         m_err;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int free_count(input logic [N-1:0] b);
    int c = 0;
    for (int i = 0; i < N; i++) if (!b[i]) c++;
    return c;
  endfunction

  function automatic logic [ID_W-1:0] lowest_free(input logic [N-1:0] b);
    for (int i = 0; i < N; i++) if (!b[i]) return ID_W'(i);
    return '0;
  endfunction

  // One clock cycle: drive after the falling edge, check 1 ns later, then let
  // the rising edge happen and advance the model.
  task automatic step(input logic r, input logic f, input logic a,
                      input logic dv, input logic [ID_W-1:0] di);
    exp_t e;
    exp_t got;
    logic rel_ok;
    @(negedge clk);
    rst = r; flush_i = f; alloc_req_i = a; dealloc_vld_i = dv; dealloc_id_i = di;

    e.busy  = m_busy;
    e.cnt   = free_count(m_busy);
    e.full  = (e.cnt == 0);
    e.empty = (e.cnt == N);
    e.err   = m_err;
    e.gnt   = a && !e.full;
    e.id    = lowest_free(m_busy);
    sb_q.push_back(e);

    #1;
    got = sb_q.pop_front();
    check("gnt",   64'(alloc_gnt_o), 64'(got.gnt));
    if (!got.full) check("id", 64'(alloc_id_o), 64'(got.id));
    check("busy",  64'(busy_vec_o),  64'(got.busy));
    check("cnt",   64'(free_cnt_o),  64'(got.cnt));
    check("full",  64'(full_o),      64'(got.full));
    check("empty", 64'(empty_o),     64'(got.empty));
    check("err",   64'(err_o),       64'(got.err));

    @(posedge clk);
    rel_ok = dv && (int'(di) < N) && m_busy[di];
    if (r) begin
      m_busy = '0;
      m_err  = 1'b0;
    end else begin
      if (dv && !rel_ok) m_err = 1'b1;
      if (f) m_busy = '0;
      else begin
        if (got.gnt) m_busy[got.id] = 1'b1;
        if (rel_ok)  m_busy[di]     = 1'b0;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Registered-output spot check, taken 1 ns after the rising edge.
  task automatic check_regs(input string tag, input logic [N-1:0] busy,
                            input int cnt, input logic err);
    #1;
    check({tag, "_busy"}, 64'(busy_vec_o), 64'(busy));
    check({tag, "_cnt"},  64'(free_cnt_o), 64'(cnt));
    check({tag, "_err"},  64'(err_o),      64'(err));
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; alloc_req_i = 1'b0;
    dealloc_vld_i = 1'b0; dealloc_id_i = '0;
    m_busy = '0; m_err = 1'b0;
    repeat (2) @(posedge clk);

    // Reset values, with a request pending to see the zero-latency grant.
    @(negedge clk);
    rst = 1'b0; alloc_req_i = 1'b1;
    #1;
    check("rst_busy",  64'(busy_vec_o), 64'h0);
    check("rst_cnt",   64'(free_cnt_o), 64'd8);
    check("rst_full",  64'(full_o),     64'd0);
    check("rst_empty", 64'(empty_o),    64'd1);
    check("rst_err",   64'(err_o),      64'd0);
    check("rst_id",    64'(alloc_id_o), 64'd0);
    check("rst_gnt",   64'(alloc_gnt_o), 64'd1);
    alloc_req_i = 1'b0;

    // Fill: nine back-to-back requests, the ninth is refused.
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_regs("fill", 8'hFF, 0, 1'b0);
    check("fill_full", 64'(full_o), 64'd1);

    // Lowest-free refill: release 5, then request.
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
    #1;
    check("refill_id", 64'(alloc_id_o), 64'd5);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_regs("refill", 8'hFF, 0, 1'b0);

    // Simultaneous grant and release from 8'h0F.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    #1;
    check("simul_id", 64'(alloc_id_o), 64'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
    check_regs("simul", 8'h1B, 4, 1'b0);
    idle();

    // Error path: release an idle entry while only entry 0 is busy.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
    check_regs("err", 8'h01, 7, 1'b1);
    repeat (2) idle();
    check_regs("err_sticky", 8'h01, 7, 1'b1);

    // Flush priority from 8'hAA with a grant and a valid release in flight.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 8; k += 2) step(1'b0, 1'b0, 1'b0, 1'b1, ID_W'(k));
    #1;
    check("pre_flush_busy", 64'(busy_vec_o), 64'hAA);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd1);
    check_regs("flush", 8'h00, 8, 1'b0);
    check("flush_empty", 64'(empty_o), 64'd1);
    idle();

    // Reset mid-operation from 8'h3C with the error flag set.
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    #1;
    check("pre_rst_busy", 64'(busy_vec_o), 64'h3C);
    check("pre_rst_err",  64'(err_o),      64'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
    check_regs("midrst", 8'h00, 8, 1'b0);

    // A short pseudo-random run against the model.
    for (int k = 0; k < 200; k++)
      step(1'b0, ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, ID_W'($urandom_range(0, N - 1)));
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
